// File: rtl/ram512_bist_if.sv
// RAM512 port bundle shared between the BIST engine and the RAM under test.
//   mem_in      : write data (BIST -> RAM)
//   mem_load    : write enable, RAM captures mem_in on the rising clock edge
//   mem_address : word address (BIST -> RAM)
//   mem_out     : read data, combinational for the current mem_address (RAM -> BIST)
// Modports: master = BIST side, slave = RAM side.
interface ram512_bist_if;
    logic [15:0] mem_in;
    logic        mem_load;
    logic [8:0]  mem_address;
    logic [15:0] mem_out;

    modport master (
        output mem_in,
        output mem_load,
        output mem_address,
        input  mem_out
    );

    modport slave (
        input  mem_in,
        input  mem_load,
        input  mem_address,
        output mem_out
    );
endinterface

// File: rtl/ram512_bist.sv
// March-style BIST for a 512x16 RAM: write pattern, read/compare, write complement,
// read/compare, then report.
//   clock, reset  : rising-edge clock, asynchronous active-high reset
//   start         : run request, honoured only in IDLE or DONE
//   mem           : RAM port bundle (master side)
//   busy          : high during the four test phases
//   done          : high from completion until the next accepted start
//   pass          : done with no mismatches
//   err_count     : read mismatches in the current/last run
//   fail_address  : address of the first mismatch, 0 if none
module ram512_bist #(
    parameter int unsigned DEPTH = 512,
    parameter logic [15:0] SEED  = 16'h000F
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    ram512_bist_if.master mem,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [10:0]   err_count,
    output logic [8:0]    fail_address
);

    typedef enum logic [2:0] {StIdle, StW0, StR0, StW1, StR1, StDone} state_e;

    localparam logic [8:0] LastAddr = 9'(DEPTH - 1);

    state_e      state_q, state_d;
    logic [8:0]  addr_q, addr_d;
    logic [10:0] err_q, err_d;
    logic [8:0]  fail_q, fail_d;
    logic        mem_load_q, mem_load_d;
    logic [8:0]  mem_address_q, mem_address_d;
    logic [15:0] mem_in_q, mem_in_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        mismatch;

    // Pass 1 uses the bitwise complement so every cell is exercised at both values.
    function automatic logic [15:0] pattern(input state_e st, input logic [8:0] a);
        logic [15:0] p;
        p = {7'b0, a} ^ SEED;
        return (st == StW1 || st == StR1) ? ~p : p;
    endfunction

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        err_d    = err_q;
        fail_d   = fail_q;
        mismatch = (state_q == StR0 || state_q == StR1) &&
                   (mem.mem_out != pattern(state_q, addr_q));

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StW0;
                    addr_d  = '0;
                    err_d   = '0;
                    fail_d  = '0;
                end
            end
            StW0, StR0, StW1, StR1: begin
                if (addr_q == LastAddr) begin
                    addr_d = '0;
                    case (state_q)
                        StW0:    state_d = StR0;
                        StR0:    state_d = StW1;
                        StW1:    state_d = StR1;
                        default: state_d = StDone;
                    endcase
                end else begin
                    addr_d = addr_q + 9'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (mismatch) begin
            err_d = err_q + 11'd1;
            // err_q is zero only until the first mismatch of the run.
            if (err_q == '0) begin
                fail_d = addr_q;
            end
        end

        // Outputs are registered from the next state so they line up with state_q.
        busy_d        = (state_d == StW0) || (state_d == StR0) ||
                        (state_d == StW1) || (state_d == StR1);
        mem_load_d    = (state_d == StW0) || (state_d == StW1);
        mem_address_d = busy_d ? addr_d : 9'd0;
        mem_in_d      = mem_load_d ? pattern(state_d, addr_d) : 16'd0;
        done_d        = (state_d == StDone);
        pass_d        = done_d && (err_d == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            err_q         <= '0;
            fail_q        <= '0;
            mem_load_q    <= 1'b0;
            mem_address_q <= '0;
            mem_in_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            err_q         <= err_d;
            fail_q        <= fail_d;
            mem_load_q    <= mem_load_d;
            mem_address_q <= mem_address_d;
            mem_in_q      <= mem_in_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
        end
    end

    assign mem.mem_load    = mem_load_q;
    assign mem.mem_address = mem_address_q;
    assign mem.mem_in      = mem_in_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign fail_address    = fail_q;

endmodule
